// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions.
//   NOP           : canonical RISC-V no-op (addi x0, x0, 0), used for bubbles
//   fetch_state_t : state of the fetch skid buffer (RUN / STALLED)
//   if_id_t       : IF/ID register layout, shared with the decode stage
package pipeline_pkg;

    localparam int XLEN = 32;
    localparam int PC_WIDTH = 8;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {
        RUN     = 1'b0,
        STALLED = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0]     instr;
        logic [PC_WIDTH-1:0] pc;
        logic [PC_WIDTH-1:0] pc_plus4;
        logic                valid;
    } if_id_t;

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer for the instruction-memory read data.
// The memory keeps re-reading the held PC while decode is stalled, so the
// word that was in flight when the stall began must be captured here and
// replayed when the stall releases.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   stall       : decode cannot accept this cycle
//   flush       : redirect; discard any captured word
//   imem_rdata  : raw memory read data (belongs to the address issued last cycle)
//   instr_out   : instruction for the IF/ID register (skid while STALLED)
module fetch_skid
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic [DATA_WIDTH-1:0] instr_out
);

    fetch_state_t          state_reg;
    logic [DATA_WIDTH-1:0] skid_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= RUN;
            skid_reg  <= '0;
        end else if (flush) begin
            // The captured word belongs to the squashed path.
            state_reg <= RUN;
            skid_reg  <= '0;
        end else if (stall) begin
            // Capture only on the first stalled cycle; afterwards imem_rdata
            // reflects a re-read of the held PC, not the in-flight word.
            if (state_reg == RUN) begin
                skid_reg  <= imem_rdata;
                state_reg <= STALLED;
            end
        end else begin
            state_reg <= RUN;
        end
    end

    assign instr_out = (state_reg == STALLED) ? skid_reg : imem_rdata;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, synchronous instruction-memory
// addressing and the IF/ID pipeline register.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   next_pc      : PC chosen by the PC mux for the next cycle
//   stall        : decode cannot accept; hold PC and IF/ID
//   flush        : redirect taken; squash in-flight fetch and IF/ID
//   pc           : current PC register
//   imem_addr    : instruction-memory read address (equals pc)
//   imem_rdata   : memory data, one cycle after the address
//   instr_d      : IF/ID instruction
//   pc_d         : IF/ID PC
//   pc_plus4_d   : pc_d + 4, wrapping at ADDRESS_WIDTH bits
//   valid_d      : IF/ID holds a real instruction
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter int                      ADDRESS_WIDTH = 8,
    parameter int                      DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC     = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] next_pc,
    input  logic                     stall,
    input  logic                     flush,
    output logic [ADDRESS_WIDTH-1:0] pc,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0]    imem_rdata,
    output logic [DATA_WIDTH-1:0]    instr_d,
    output logic [ADDRESS_WIDTH-1:0] pc_d,
    output logic [ADDRESS_WIDTH-1:0] pc_plus4_d,
    output logic                     valid_d
);

    localparam logic [DATA_WIDTH-1:0]    NOP_WORD = DATA_WIDTH'(NOP);
    localparam logic [ADDRESS_WIDTH-1:0] FOUR     = ADDRESS_WIDTH'(4);

    logic [ADDRESS_WIDTH-1:0] pc_reg;
    logic [ADDRESS_WIDTH-1:0] f_pc_reg;     // address issued last cycle
    logic                     f_valid_reg;  // that read is live (not squashed)

    logic [DATA_WIDTH-1:0]    instr_d_reg;
    logic [ADDRESS_WIDTH-1:0] pc_d_reg;
    logic [ADDRESS_WIDTH-1:0] pc_plus4_d_reg;
    logic                     valid_d_reg;

    logic [DATA_WIDTH-1:0]    fetched_instr;

    fetch_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .imem_rdata (imem_rdata),
        .instr_out  (fetched_instr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg         <= RESET_PC;
            f_pc_reg       <= '0;
            f_valid_reg    <= 1'b0;
            instr_d_reg    <= NOP_WORD;
            pc_d_reg       <= '0;
            pc_plus4_d_reg <= FOUR;
            valid_d_reg    <= 1'b0;
        end else if (flush) begin
            // pc_d / pc_plus4_d deliberately hold; only the valid bit and
            // instruction are squashed.
            pc_reg      <= next_pc;
            f_valid_reg <= 1'b0;
            instr_d_reg <= NOP_WORD;
            valid_d_reg <= 1'b0;
        end else if (!stall) begin
            pc_reg         <= next_pc;
            f_pc_reg       <= pc_reg;
            f_valid_reg    <= 1'b1;
            instr_d_reg    <= f_valid_reg ? fetched_instr : NOP_WORD;
            pc_d_reg       <= f_pc_reg;
            pc_plus4_d_reg <= f_pc_reg + FOUR;
            valid_d_reg    <= f_valid_reg;
        end
    end

    assign pc         = pc_reg;
    assign imem_addr  = pc_reg;
    assign instr_d    = instr_d_reg;
    assign pc_d       = pc_d_reg;
    assign pc_plus4_d = pc_plus4_d_reg;
    assign valid_d    = valid_d_reg;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam logic [31:0] NOP_W = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [7:0]  next_pc;
    logic        stall;
    logic        flush;
    logic [7:0]  pc;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instr_d;
    logic [7:0]  pc_d;
    logic [7:0]  pc_plus4_d;
    logic        valid_d;

    logic        use_target;
    logic [7:0]  target;

    logic [31:0] mem [64];
    logic [7:0]  exp_q [$];

    int errors;
    int checks;

    fetch_stage #(
        .ADDRESS_WIDTH (8),
        .DATA_WIDTH    (32),
        .RESET_PC      (8'h00)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .next_pc    (next_pc),
        .stall      (stall),
        .flush      (flush),
        .pc         (pc),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .instr_d    (instr_d),
        .pc_d       (pc_d),
        .pc_plus4_d (pc_plus4_d),
        .valid_d    (valid_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous instruction memory: data one cycle after the address.
    always @(posedge clk) imem_rdata <= mem[imem_addr[7:2]];

    // PC mux model: sequential unless a redirect target is selected.
    always_comb begin
        next_pc = pc + 8'd4;
        if (use_target) next_pc = target;
    end

    // Scoreboard: decode consumes IF/ID whenever it is valid and not stalled.
    always @(negedge clk) begin
        logic [7:0]  a;
        logic [7:0]  a4;
        logic [31:0] ei;
        if (!rst && valid_d && !stall && exp_q.size() > 0) begin
            a  = exp_q.pop_front();
            a4 = a + 8'd4;
            ei = mem[a[7:2]];
            checks++;
            if (pc_d !== a || instr_d !== ei || pc_plus4_d !== a4) begin
                errors++;
                $display("FAIL txn: got pc_d=%h instr_d=%h pc_plus4_d=%h, want pc_d=%h instr_d=%h pc_plus4_d=%h",
                         pc_d, instr_d, pc_plus4_d, a, ei, a4);
            end else begin
                $display("txn pc_d=%h instr_d=%h pc_plus4_d=%h", pc_d, instr_d, pc_plus4_d);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; stall = 1'b0; flush = 1'b0; use_target = 1'b0; target = 8'h00;
        exp_q.delete();
        tick; tick;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; stall = 1'b0; flush = 1'b0; use_target = 1'b0; target = 8'h00;
        tick; tick;
        @(negedge clk);
        checks++;
        if (pc !== 8'h00 || imem_addr !== 8'h00 || instr_d !== NOP_W || pc_d !== 8'h00 ||
            pc_plus4_d !== 8'h04 || valid_d !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: pc=%h addr=%h instr_d=%h pc_d=%h pc4=%h valid=%b, want 00 00 00000013 00 04 0",
                     pc, imem_addr, instr_d, pc_d, pc_plus4_d, valid_d);
        end
    endtask

    task automatic test_free_run;
        do_reset;
        for (int i = 0; i < 8; i++) exp_q.push_back(8'(i * 4));
        @(negedge clk);
        checks++;
        if (valid_d !== 1'b0) begin errors++; $display("FAIL first_valid_c0: valid_d=%b want 0", valid_d); end
        tick;
        @(negedge clk);
        checks++;
        if (valid_d !== 1'b0) begin errors++; $display("FAIL first_valid_c1: valid_d=%b want 0", valid_d); end
        tick;
        @(negedge clk);
        checks++;
        if (valid_d !== 1'b1 || instr_d !== 32'h1000_0000 || pc_d !== 8'h00 || pc_plus4_d !== 8'h04) begin
            errors++;
            $display("FAIL first_valid_c2: valid=%b instr=%h pc_d=%h pc4=%h want 1 10000000 00 04",
                     valid_d, instr_d, pc_d, pc_plus4_d);
        end
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick;
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL free_run_drain: left=%0d want 0", exp_q.size()); end
    endtask

    task automatic test_stall;
        int found;
        do_reset;
        for (int i = 0; i < 8; i++) exp_q.push_back(8'(i * 4));
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (valid_d && pc_d == 8'h08) begin found = 1; break; end
            tick;
        end
        checks++;
        if (found == 0) begin errors++; $display("FAIL stall_reach: pc_d=%h want 08", pc_d); end
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (pc_d !== 8'h08 || valid_d !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold%0d: pc_d=%h valid=%b want 08 1", k, pc_d, valid_d);
            end
            tick;
        end
        stall = 1'b0;
        @(negedge clk);
        checks++;
        if (pc_d !== 8'h08) begin errors++; $display("FAIL stall_last: pc_d=%h want 08", pc_d); end
        tick;
        @(negedge clk);
        checks++;
        if (pc_d !== 8'h0C || instr_d !== mem[3] || valid_d !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: pc_d=%h instr=%h valid=%b want 0c %h 1", pc_d, instr_d, valid_d, mem[3]);
        end
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick;
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL stall_drain: left=%0d want 0", exp_q.size()); end
    endtask

    task automatic test_flush;
        int found;
        do_reset;
        exp_q.push_back(8'h00); exp_q.push_back(8'h04); exp_q.push_back(8'h08); exp_q.push_back(8'h0C);
        exp_q.push_back(8'h40); exp_q.push_back(8'h44); exp_q.push_back(8'h48);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (pc == 8'h14) begin found = 1; break; end
            tick;
        end
        checks++;
        if (found == 0) begin errors++; $display("FAIL flush_reach: pc=%h want 14", pc); end
        flush = 1'b1; use_target = 1'b1; target = 8'h40;
        tick;
        flush = 1'b0; use_target = 1'b0;
        @(negedge clk);
        checks++;
        if (valid_d !== 1'b0 || instr_d !== NOP_W || pc_d !== 8'h0C || pc !== 8'h40) begin
            errors++;
            $display("FAIL flush_bubble: valid=%b instr=%h pc_d=%h pc=%h want 0 00000013 0c 40",
                     valid_d, instr_d, pc_d, pc);
        end
        tick;
        @(negedge clk);
        checks++;
        if (valid_d !== 1'b0) begin errors++; $display("FAIL flush_bubble2: valid=%b want 0", valid_d); end
        tick;
        @(negedge clk);
        checks++;
        if (valid_d !== 1'b1 || pc_d !== 8'h40) begin
            errors++;
            $display("FAIL flush_target: valid=%b pc_d=%h want 1 40", valid_d, pc_d);
        end
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick;
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL flush_drain: left=%0d want 0", exp_q.size()); end
    endtask

    task automatic test_flush_stall;
        int found;
        do_reset;
        exp_q.push_back(8'h00); exp_q.push_back(8'h04);
        exp_q.push_back(8'h80); exp_q.push_back(8'h84); exp_q.push_back(8'h88);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (pc == 8'h10) begin found = 1; break; end
            tick;
        end
        checks++;
        if (found == 0) begin errors++; $display("FAIL flush_stall_reach: pc=%h want 10", pc); end
        stall = 1'b1; flush = 1'b1; use_target = 1'b1; target = 8'h80;
        tick;
        stall = 1'b0; flush = 1'b0; use_target = 1'b0;
        @(negedge clk);
        checks++;
        if (pc !== 8'h80 || valid_d !== 1'b0 || instr_d !== NOP_W) begin
            errors++;
            $display("FAIL flush_over_stall: pc=%h valid=%b instr=%h want 80 0 00000013", pc, valid_d, instr_d);
        end
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick;
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL flush_stall_drain: left=%0d want 0", exp_q.size()); end
    endtask

    task automatic test_reset_stalled;
        int found;
        do_reset;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (valid_d && pc_d == 8'h08) begin found = 1; break; end
            tick;
        end
        checks++;
        if (found == 0) begin errors++; $display("FAIL rst_stall_reach: pc_d=%h want 08", pc_d); end
        stall = 1'b1;
        tick; tick;
        rst = 1'b1;
        exp_q.delete();
        tick;
        @(negedge clk);
        checks++;
        if (pc !== 8'h00 || imem_addr !== 8'h00 || instr_d !== NOP_W || pc_d !== 8'h00 ||
            pc_plus4_d !== 8'h04 || valid_d !== 1'b0) begin
            errors++;
            $display("FAIL rst_stall_values: pc=%h addr=%h instr=%h pc_d=%h pc4=%h valid=%b want 00 00 00000013 00 04 0",
                     pc, imem_addr, instr_d, pc_d, pc_plus4_d, valid_d);
        end
        tick;
        rst = 1'b0; stall = 1'b0;
        exp_q.push_back(8'h00); exp_q.push_back(8'h04); exp_q.push_back(8'h08);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (valid_d !== 1'b0 || instr_d === mem[3]) begin
                errors++;
                $display("FAIL rst_stall_noskid%0d: valid=%b instr=%h want 0 and not %h", k, valid_d, instr_d, mem[3]);
            end
            tick;
        end
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick;
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL rst_stall_drain: left=%0d want 0", exp_q.size()); end
    endtask

    task automatic test_wrap;
        int found;
        do_reset;
        exp_q.push_back(8'hF8); exp_q.push_back(8'hFC); exp_q.push_back(8'h00); exp_q.push_back(8'h04);
        flush = 1'b1; use_target = 1'b1; target = 8'hF8;
        tick;
        flush = 1'b0; use_target = 1'b0;
        tick;
        checks++;
        if (pc !== 8'hFC) begin errors++; $display("FAIL wrap_pc_fc: pc=%h want fc", pc); end
        tick;
        checks++;
        if (pc !== 8'h00) begin errors++; $display("FAIL wrap_pc_00: pc=%h want 00", pc); end
        found = 0;
        for (int i = 0; i < 10; i++) begin
            if (valid_d && pc_d == 8'hFC) begin found = 1; break; end
            tick;
        end
        @(negedge clk);
        checks++;
        if (found == 0 || pc_plus4_d !== 8'h00) begin
            errors++;
            $display("FAIL wrap_pc4: found=%0d pc_d=%h pc_plus4_d=%h want fc 00", found, pc_d, pc_plus4_d);
        end
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick;
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_drain: left=%0d want 0", exp_q.size()); end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        errors = 0;
        checks = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i);
        rst = 1'b1; stall = 1'b0; flush = 1'b0; use_target = 1'b0; target = 8'h00;
        test_reset;
        test_free_run;
        test_stall;
        test_flush;
        test_flush_stall;
        test_reset_stalled;
        test_wrap;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
